// File: rtl/ct_loader_if.sv
// ct_loader_if: the signal bundle around the ARC4 ciphertext loader.
//   Upstream stream : in_valid, in_data[7:0], in_last (to loader); in_ready (from loader)
//   ct_mem port     : ct_addr[7:0], ct_wrdata[7:0], ct_wren (from loader)
//   Cracker         : crack_en (from loader); crack_rdy (to loader)
//   Status          : msg_len[7:0], done, overflow (from loader)
// The master modport is the loader. The slave modport is its environment:
// the upstream source, ct_mem, the cracker and whatever reads the status.
interface ct_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic [7:0] ct_addr;
  logic [7:0] ct_wrdata;
  logic       ct_wren;
  logic       crack_en;
  logic       crack_rdy;
  logic [7:0] msg_len;
  logic       done;
  logic       overflow;

  modport master (
    input  in_valid, in_data, in_last, crack_rdy,
    output in_ready, ct_addr, ct_wrdata, ct_wren, crack_en, msg_len, done, overflow
  );

  modport slave (
    output in_valid, in_data, in_last, crack_rdy,
    input  in_ready, ct_addr, ct_wrdata, ct_wren, crack_en, msg_len, done, overflow
  );
endinterface

// File: rtl/ct_loader.sv
// ct_loader: the upstream stage of the ARC4 key cracker.
// It takes a ciphertext byte stream (valid/ready, with in_last marking the
// final byte) and writes it into ct_mem in length-prefixed form: the bytes go
// to addresses 1..N, then N goes to address 0. It then starts the cracker
// through en/rdy and pulses done when the cracker is idle again.
// Ports:
//   clk   system clock; all state changes on the rising edge
//   rst   asynchronous reset, active high
//   bus   ct_loader_if.master (upstream stream, ct_mem write port, cracker, status)
// Every output is driven straight from a register.
module ct_loader #(
  parameter int MAX_LEN = 255  // must be <= 255 so that N fits in byte 0
) (
  input  logic         clk,
  input  logic         rst,
  ct_loader_if.master  bus
);

  typedef enum logic [2:0] {LOAD, WRLEN, START, WAIT_BUSY, WAIT_DONE} state_t;

  // Counter value when the MAX_LEN-th beat is accepted.
  localparam logic [7:0] LAST_IDX = 8'(MAX_LEN - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] wait_q, wait_d;
  logic       reiss_q, reiss_d;
  logic       in_ready_q, in_ready_d;
  logic [7:0] ct_addr_q, ct_addr_d;
  logic [7:0] ct_wrdata_q, ct_wrdata_d;
  logic       ct_wren_q, ct_wren_d;
  logic       crack_en_q, crack_en_d;
  logic [7:0] msg_len_q, msg_len_d;
  logic       done_q, done_d;
  logic       overflow_q, overflow_d;
  logic       beat;

  // A beat is accepted only through the registered in_ready. Holding
  // in_valid high while in_ready is low therefore cannot repeat a write.
  assign beat = bus.in_valid & in_ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    reiss_d     = reiss_q;
    in_ready_d  = 1'b0;
    ct_addr_d   = ct_addr_q;
    ct_wrdata_d = ct_wrdata_q;
    ct_wren_d   = 1'b0;
    crack_en_d  = 1'b0;
    msg_len_d   = msg_len_q;
    done_d      = 1'b0;
    overflow_d  = overflow_q;
    unique case (state_q)
      LOAD: begin
        in_ready_d = 1'b1;
        if (beat) begin
          cnt_d       = cnt_q + 8'd1;
          ct_wren_d   = 1'b1;
          ct_addr_d   = cnt_q + 8'd1;
          ct_wrdata_d = bus.in_data;
          // The first beat of a message clears the previous message's overflow.
          if (cnt_q == 8'd0) overflow_d = 1'b0;
          if (bus.in_last) begin
            state_d    = WRLEN;
            in_ready_d = 1'b0;
          end else if (cnt_q == LAST_IDX) begin
            // Message is truncated at MAX_LEN. The rest of the stream is
            // left to wait until the next LOAD.
            overflow_d = 1'b1;
            state_d    = WRLEN;
            in_ready_d = 1'b0;
          end
        end
      end
      WRLEN: begin
        ct_wren_d   = 1'b1;
        ct_addr_d   = 8'd0;
        ct_wrdata_d = cnt_q;
        msg_len_d   = cnt_q;
        wait_d      = 2'd0;
        reiss_d     = 1'b0;
        state_d     = START;
      end
      START: begin
        if (bus.crack_rdy) begin
          crack_en_d = 1'b1;
          state_d    = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        // If rdy is still high after 4 cycles, the cracker missed the start.
        // Re-issue en once, then keep waiting.
        if (!bus.crack_rdy) begin
          state_d = WAIT_DONE;
        end else if (wait_q == 2'd3) begin
          if (!reiss_q) begin
            crack_en_d = 1'b1;
            reiss_d    = 1'b1;
          end
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      WAIT_DONE: begin
        if (bus.crack_rdy) begin
          done_d     = 1'b1;
          cnt_d      = 8'd0;
          in_ready_d = 1'b1;
          state_d    = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      cnt_q       <= 8'd0;
      wait_q      <= 2'd0;
      reiss_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      ct_addr_q   <= 8'd0;
      ct_wrdata_q <= 8'd0;
      ct_wren_q   <= 1'b0;
      crack_en_q  <= 1'b0;
      msg_len_q   <= 8'd0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      reiss_q     <= reiss_d;
      in_ready_q  <= in_ready_d;
      ct_addr_q   <= ct_addr_d;
      ct_wrdata_q <= ct_wrdata_d;
      ct_wren_q   <= ct_wren_d;
      crack_en_q  <= crack_en_d;
      msg_len_q   <= msg_len_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.ct_addr   = ct_addr_q;
  assign bus.ct_wrdata = ct_wrdata_q;
  assign bus.ct_wren   = ct_wren_q;
  assign bus.crack_en  = crack_en_q;
  assign bus.msg_len   = msg_len_q;
  assign bus.done      = done_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_ct_loader.sv
// Directed testbench for ct_loader: a linear sequence of steps with
// hand-computed expectations, each checked by an immediate assertion.
module tb_ct_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ct_loader_if bus();

  ct_loader #(.MAX_LEN(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int total = 0;
  int bad   = 0;
  logic [15:0] wq[$];   // {addr, data} of every ct_mem write
  int enc = 0;          // crack_en cycles seen
  int dnc = 0;          // done cycles seen
  int n, viol, errs, beats, e0, d0;
  logic acc;

  // Monitor on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ct_wren)  wq.push_back({bus.ct_addr, bus.ct_wrdata});
      if (bus.crack_en) enc++;
      if (bus.done)     dnc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] wget(input int i);
    if (i < wq.size()) return wq[i];
    return 16'hxxxx;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
    chk({tag, "_ct_addr"},   32'(bus.ct_addr),   32'd0);
    chk({tag, "_ct_wrdata"}, 32'(bus.ct_wrdata), 32'd0);
    chk({tag, "_ct_wren"},   32'(bus.ct_wren),   32'd0);
    chk({tag, "_crack_en"},  32'(bus.crack_en),  32'd0);
    chk({tag, "_msg_len"},   32'(bus.msg_len),   32'd0);
    chk({tag, "_done"},      32'(bus.done),      32'd0);
    chk({tag, "_overflow"},  32'(bus.overflow),  32'd0);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  // Present one beat and keep it until accepted (in_ready is registered, so
  // its value just after an edge decides the next edge).
  task automatic send(input logic [7:0] d, input logic l);
    int k;
    logic a;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    k = 0;
    do begin
      a = bus.in_ready;
      tick();
      k++;
    end while (!a && k < 50);
    chk("send_accepted", 32'(a), 32'd1);
  endtask

  // Cracker model: rdy drops one cycle after en and returns after 'busy' cycles.
  task automatic crack(input int busy);
    int k;
    int v;
    k = 0;
    while (!bus.crack_en && k < 50) begin tick(); k++; end
    chk("crack_en_seen", 32'(bus.crack_en), 32'd1);
    bus.crack_rdy = 1'b0;
    v = 0;
    repeat (busy) begin
      tick();
      if (bus.in_ready) v++;
    end
    chk("busy_in_ready_low", 32'(v), 32'd0);
    bus.crack_rdy = 1'b1;
    k = 0;
    while (!bus.done && k < 20) begin tick(); k++; end
    chk("done_seen", 32'(bus.done), 32'd1);
    tick();
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("ready_after_done", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    idle();
    bus.crack_rdy = 1'b1;

    // Reset state, then in_ready low for exactly the first cycle after release.
    #2;
    chk_reset("rst0");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("ready_first_cycle", 32'(bus.in_ready), 32'd0);
    tick();
    chk("ready_second_cycle", 32'(bus.in_ready), 32'd1);

    // Three bytes back to back.
    wq.delete(); e0 = enc; d0 = dnc;
    send(8'hA1, 1'b0);
    send(8'hB2, 1'b0);
    send(8'hC3, 1'b1);
    idle();
    crack(5);
    chk("m3_nwr",  32'(wq.size()), 32'd4);
    chk("m3_wr0",  32'(wget(0)), 32'h01A1);
    chk("m3_wr1",  32'(wget(1)), 32'h02B2);
    chk("m3_wr2",  32'(wget(2)), 32'h03C3);
    chk("m3_wr3",  32'(wget(3)), 32'h0003);
    chk("m3_len",  32'(bus.msg_len), 32'd3);
    chk("m3_en",   32'(enc - e0), 32'd1);
    chk("m3_done", 32'(dnc - d0), 32'd1);
    chk("m3_ovf",  32'(bus.overflow), 32'd0);

    // Single byte, with an in_valid=0 cycle carrying junk data and last.
    wq.delete();
    bus.in_valid = 1'b0; bus.in_data = 8'hFF; bus.in_last = 1'b1;
    tick();
    send(8'h5E, 1'b1);
    idle();
    crack(2);
    chk("m1_nwr", 32'(wq.size()), 32'd2);
    chk("m1_wr0", 32'(wget(0)), 32'h015E);
    chk("m1_wr1", 32'(wget(1)), 32'h0001);
    chk("m1_len", 32'(bus.msg_len), 32'd1);
    chk("m1_ovf", 32'(bus.overflow), 32'd0);

    // 300 beats with no last and the cracker busy: truncation at 255.
    wq.delete(); e0 = enc; d0 = dnc;
    bus.crack_rdy = 1'b0;
    bus.in_valid = 1'b1; bus.in_last = 1'b0; bus.in_data = 8'h01 ^ 8'h5A;
    beats = 0; viol = 0;
    for (int c = 0; c < 300; c++) begin
      acc = bus.in_ready;
      if (beats >= 255 && acc) viol++;
      tick();
      if (acc) begin
        beats++;
        bus.in_data = 8'(beats + 1) ^ 8'h5A;
      end
    end
    chk("ovf_beats", 32'(beats), 32'd255);
    chk("ovf_ready_after_255", 32'(viol), 32'd0);
    // Still held in START: valid stays high, rdy low for 20 more cycles.
    viol = 0;
    repeat (20) begin
      tick();
      if (bus.crack_en || bus.in_ready) viol++;
    end
    chk("start_hold_quiet", 32'(viol), 32'd0);
    chk("start_hold_en_cnt", 32'(enc - e0), 32'd0);
    idle();
    chk("ovf_nwr", 32'(wq.size()), 32'd256);
    errs = 0;
    for (int k = 1; k <= 255; k++)
      if (wget(k - 1) !== {8'(k), 8'(k) ^ 8'h5A}) errs++;
    chk("ovf_data_writes", 32'(errs), 32'd0);
    chk("ovf_len_write", 32'(wget(255)), 32'h00FF);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    chk("ovf_len", 32'(bus.msg_len), 32'hFF);
    bus.crack_rdy = 1'b1;
    tick();
    chk("en_after_rdy", 32'(bus.crack_en), 32'd1);
    crack(500);
    chk("ovf_en_cnt", 32'(enc - e0), 32'd1);
    chk("ovf_done_cnt", 32'(dnc - d0), 32'd1);
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Next message: overflow clears on its first beat.
    wq.delete();
    send(8'h11, 1'b0);
    chk("ovf_cleared", 32'(bus.overflow), 32'd0);
    send(8'h22, 1'b1);
    idle();
    crack(3);
    chk("m2_nwr", 32'(wq.size()), 32'd3);
    chk("m2_wr0", 32'(wget(0)), 32'h0111);
    chk("m2_wr1", 32'(wget(1)), 32'h0222);
    chk("m2_wr2", 32'(wget(2)), 32'h0002);
    chk("m2_len", 32'(bus.msg_len), 32'd2);

    // Cracker ignores en: exactly one re-issue.
    e0 = enc;
    send(8'h77, 1'b1);
    idle();
    repeat (16) tick();
    chk("reissue_en_cnt", 32'(enc - e0), 32'd2);
    bus.crack_rdy = 1'b0;
    repeat (2) tick();
    bus.crack_rdy = 1'b1;
    n = 0;
    while (!bus.done && n < 20) begin tick(); n++; end
    chk("reissue_done", 32'(bus.done), 32'd1);
    tick();

    // Reset while in WAIT_DONE.
    send(8'h66, 1'b1);
    idle();
    n = 0;
    while (!bus.crack_en && n < 50) begin tick(); n++; end
    chk("wd_en_seen", 32'(bus.crack_en), 32'd1);
    bus.crack_rdy = 1'b0;
    repeat (5) tick();
    chk("wd_len_before", 32'(bus.msg_len), 32'd1);
    #3 rst = 1'b1;
    #1 chk_reset("rst_wd");
    @(posedge clk); #1;
    rst = 1'b0;
    bus.crack_rdy = 1'b1;
    d0 = dnc;
    repeat (4) tick();
    chk("wd_no_done", 32'(dnc - d0), 32'd0);

    // Reset in LOAD while beat 2 is presented.
    send(8'h31, 1'b0);
    chk("ld_wren_before", 32'(bus.ct_wren), 32'd1);
    bus.in_data = 8'h32;
    #2 rst = 1'b1;
    #1 chk_reset("rst_ld");
    idle();
    @(posedge clk); #1;
    rst = 1'b0;
    wq.delete();
    send(8'h41, 1'b0);
    send(8'h42, 1'b1);
    idle();
    crack(2);
    chk("rl_nwr", 32'(wq.size()), 32'd3);
    chk("rl_wr0", 32'(wget(0)), 32'h0141);
    chk("rl_wr1", 32'(wget(1)), 32'h0242);
    chk("rl_wr2", 32'(wget(2)), 32'h0002);
    chk("rl_len", 32'(bus.msg_len), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
